// File: rtl/axis_src_pkg.sv
`default_nettype none
// ============================================================================
// axis_src_pkg : shared constants and elaboration helpers for axis_stream_source
// Revision     : 1.0
// ============================================================================
package axis_src_pkg;

   localparam int COUNT_WIDTH = 32;

   function automatic int keep_width(input int data_width);
      return data_width / 8;
   endfunction

   function automatic bit is_byte_multiple(input int width);
      return (width > 0) && ((width % 8) == 0);
   endfunction

   function automatic bit is_pow2_min2(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_src_fifo.sv
`default_nettype none
// ============================================================================
// axis_src_fifo : single-clock show-ahead FIFO holding packed beat payloads
// Revision      : 1.0
// ============================================================================
module axis_src_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int c_aw = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wptr;
   logic [c_aw-1:0]  r_rptr;
   logic [c_aw:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // Fullness comes from the registered count only, so a push while full is
   // refused even when a pop frees a slot on the same edge.
   assign o_full    = (r_count == (c_aw+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + c_aw'(1);
         if (w_do_pop)  r_rptr <= r_rptr + c_aw'(1);
         r_count <= r_count + (c_aw+1)'(w_do_push) - (c_aw+1)'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_wdata;
   end

endmodule
`default_nettype wire

// File: rtl/axis_stream_source.sv
`default_nettype none
// ============================================================================
// axis_stream_source : FIFO-backed AXI4-Stream master with gap and counters
// Revision           : 1.0
// ============================================================================
module axis_stream_source
   import axis_src_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEST_WIDTH = 8,
   parameter int USER_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int GAP_WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              wr_en,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   input  logic [keep_width(DATA_WIDTH)-1:0] wr_keep,
   input  logic [DEST_WIDTH-1:0]             wr_dest,
   input  logic [USER_WIDTH-1:0]             wr_user,
   input  logic                              wr_last,
   output logic                              wr_full,
   input  logic                              enable,
   input  logic [GAP_WIDTH-1:0]              gap,
   output logic [DATA_WIDTH-1:0]             m_axis_tdata,
   output logic [keep_width(DATA_WIDTH)-1:0] m_axis_tkeep,
   output logic [DEST_WIDTH-1:0]             m_axis_tdest,
   output logic [USER_WIDTH-1:0]             m_axis_tuser,
   output logic                              m_axis_tlast,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic [$clog2(DEPTH)+1:0]          level,
   output logic [COUNT_WIDTH-1:0]            beat_count,
   output logic [COUNT_WIDTH-1:0]            pkt_count,
   output logic                              overflow
);

   localparam int c_kw    = keep_width(DATA_WIDTH);
   localparam int c_pw    = DATA_WIDTH + c_kw + DEST_WIDTH + USER_WIDTH + 1;
   localparam int c_cnt_w = $clog2(DEPTH) + 1;
   localparam int c_lvl_w = $clog2(DEPTH) + 2;

   if (!is_byte_multiple(DATA_WIDTH)) begin : g_chk_data_width
      $error("axis_stream_source: DATA_WIDTH must be a multiple of 8");
   end
   if (!is_pow2_min2(DEPTH)) begin : g_chk_depth
      $error("axis_stream_source: DEPTH must be a power of two and >= 2");
   end

   logic [c_pw-1:0]       w_wpayload;
   logic [c_pw-1:0]       w_head;
   logic                  w_fifo_empty;
   logic [c_cnt_w-1:0]    w_fifo_count;
   logic                  w_hs;
   logic                  w_gap_ok;
   logic                  w_load;

   logic [DATA_WIDTH-1:0] w_h_data;
   logic [c_kw-1:0]       w_h_keep;
   logic [DEST_WIDTH-1:0] w_h_dest;
   logic [USER_WIDTH-1:0] w_h_user;
   logic                  w_h_last;

   logic [DATA_WIDTH-1:0] r_tdata;
   logic [c_kw-1:0]       r_tkeep;
   logic [DEST_WIDTH-1:0] r_tdest;
   logic [USER_WIDTH-1:0] r_tuser;
   logic                  r_tlast;
   logic                  r_tvalid;
   logic [GAP_WIDTH-1:0]  r_gap;
   logic [COUNT_WIDTH-1:0] r_beat_count;
   logic [COUNT_WIDTH-1:0] r_pkt_count;
   logic                  r_overflow;

   assign w_wpayload = {wr_data, wr_keep, wr_dest, wr_user, wr_last};
   assign {w_h_data, w_h_keep, w_h_dest, w_h_user, w_h_last} = w_head;

   axis_src_fifo #(
      .WIDTH (c_pw),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (wr_en),
      .i_wdata (w_wpayload),
      .i_pop   (w_load),
      .o_rdata (w_head),
      .o_full  (wr_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign w_hs = r_tvalid & m_axis_tready;

   // The counter is loaded with `gap` on the handshake edge and a new beat may
   // be loaded on the edge where it steps from 1 to 0, giving exactly `gap`
   // idle cycles; with gap=0 the refill happens on the handshake edge itself.
   assign w_gap_ok = w_hs ? (gap == '0) : (r_gap <= GAP_WIDTH'(1));
   assign w_load   = ~w_fifo_empty & enable & w_gap_ok & (~r_tvalid | w_hs);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tdata      <= '0;
         r_tkeep      <= '0;
         r_tdest      <= '0;
         r_tuser      <= '0;
         r_tlast      <= 1'b0;
         r_tvalid     <= 1'b0;
         r_gap        <= '0;
         r_beat_count <= '0;
         r_pkt_count  <= '0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_load) begin
            r_tdata  <= w_h_data;
            r_tkeep  <= w_h_keep;
            r_tdest  <= w_h_dest;
            r_tuser  <= w_h_user;
            r_tlast  <= w_h_last;
            r_tvalid <= 1'b1;
         end else if (w_hs) begin
            r_tvalid <= 1'b0;
         end

         if (w_hs) begin
            r_gap        <= gap;
            r_beat_count <= r_beat_count + COUNT_WIDTH'(1);
            r_pkt_count  <= r_pkt_count + COUNT_WIDTH'(r_tlast);
         end else if (r_gap != '0) begin
            r_gap <= r_gap - GAP_WIDTH'(1);
         end

         if (wr_en & wr_full) r_overflow <= 1'b1;
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tkeep  = r_tkeep;
   assign m_axis_tdest  = r_tdest;
   assign m_axis_tuser  = r_tuser;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tvalid = r_tvalid;
   assign level         = c_lvl_w'(w_fifo_count) + c_lvl_w'(r_tvalid);
   assign beat_count    = r_beat_count;
   assign pkt_count     = r_pkt_count;
   assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_axis_stream_source.sv
`default_nettype none
// ============================================================================
// tb_axis_stream_source : directed bench with queue-based reference model
// Revision              : 1.0
// ============================================================================
module tb_axis_stream_source;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic [7:0]  dest;
      logic [7:0]  user;
      logic        last;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [63:0] wr_data;
   logic [7:0]  wr_keep;
   logic [7:0]  wr_dest;
   logic [7:0]  wr_user;
   logic        wr_last;
   logic        wr_full;
   logic        enable;
   logic [7:0]  gap;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic [7:0]  m_axis_tdest;
   logic [7:0]  m_axis_tuser;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [5:0]  level;
   logic [31:0] beat_count;
   logic [31:0] pkt_count;
   logic        overflow;

   axis_stream_source #(
      .DATA_WIDTH (64),
      .DEST_WIDTH (8),
      .USER_WIDTH (8),
      .DEPTH      (DEPTH),
      .GAP_WIDTH  (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .wr_keep       (wr_keep),
      .wr_dest       (wr_dest),
      .wr_user       (wr_user),
      .wr_last       (wr_last),
      .wr_full       (wr_full),
      .enable        (enable),
      .gap           (gap),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tdest  (m_axis_tdest),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .level         (level),
      .beat_count    (beat_count),
      .pkt_count     (pkt_count),
      .overflow      (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: ordered queue of accepted beats, occupancy and counters
   // derived purely from pushes accepted and handshakes seen on the port.
   beat_t       exp_q[$];
   int          exp_level = 0;
   logic [31:0] exp_beats = '0;
   logic [31:0] exp_pkts  = '0;
   logic        exp_ovf   = 1'b0;
   bit          live      = 1'b0;
   bit          hold      = 1'b0;
   beat_t       held;

   always @(negedge clk) begin
      beat_t cur;
      beat_t popped;
      int    fifo_cnt;
      bit    pushed;
      bit    hs;
      cur = {m_axis_tdata, m_axis_tkeep, m_axis_tdest, m_axis_tuser, m_axis_tlast};
      if (live) begin
         chk("m_level",    128'(level),      128'(exp_level));
         chk("m_beats",    128'(beat_count), 128'(exp_beats));
         chk("m_pkts",     128'(pkt_count),  128'(exp_pkts));
         chk("m_overflow", 128'(overflow),   128'(exp_ovf));
         chk("m_wr_full",  128'(wr_full),
             128'((exp_level - int'(m_axis_tvalid)) >= DEPTH));
         if (hold) begin
            chk("m_hold_valid",   128'(m_axis_tvalid), 128'(1));
            chk("m_hold_payload", 128'(cur),           128'(held));
         end
         if (m_axis_tvalid) begin
            if (exp_q.size() == 0) chk("m_unexpected_beat", 128'(1), 128'(0));
            else                   chk("m_beat_payload", 128'(cur), 128'(exp_q[0]));
         end
      end
      if (!rst_n) begin
         exp_q.delete();
         exp_level = 0;
         exp_beats = '0;
         exp_pkts  = '0;
         exp_ovf   = 1'b0;
         hold      = 1'b0;
         live      = 1'b1;
      end else if (live) begin
         hs       = m_axis_tvalid && m_axis_tready;
         fifo_cnt = exp_level - int'(m_axis_tvalid);
         pushed   = 1'b0;
         if (wr_en) begin
            if (fifo_cnt < DEPTH) begin
               exp_q.push_back({wr_data, wr_keep, wr_dest, wr_user, wr_last});
               pushed = 1'b1;
            end else begin
               exp_ovf = 1'b1;
            end
         end
         if (hs) begin
            exp_beats = exp_beats + 32'd1;
            if (exp_q.size() > 0) begin
               popped = exp_q.pop_front();
               if (popped.last) exp_pkts = exp_pkts + 32'd1;
            end
         end
         exp_level = exp_level + int'(pushed) - int'(hs);
         hold = m_axis_tvalid && !m_axis_tready;
         held = cur;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] d, input logic [7:0] k, input logic [7:0] de,
                       input logic [7:0] u, input logic l);
      wr_data = d;
      wr_keep = k;
      wr_dest = de;
      wr_user = u;
      wr_last = l;
      wr_en   = 1'b1;
      tick();
      wr_en   = 1'b0;
   endtask

   logic [15:0] pat;
   int          cnt;

   initial begin
      rst_n = 1'b0;  wr_en = 1'b0;  wr_data = '0;  wr_keep = '0;  wr_dest = '0;
      wr_user = '0;  wr_last = 1'b0;  enable = 1'b1;  gap = '0;  m_axis_tready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      chk("rst_tvalid",   128'(m_axis_tvalid), 128'(0));
      chk("rst_tdata",    128'(m_axis_tdata),  128'(0));
      chk("rst_level",    128'(level),         128'(0));
      chk("rst_wr_full",  128'(wr_full),       128'(0));
      chk("rst_overflow", 128'(overflow),      128'(0));
      chk("rst_beats",    128'(beat_count),    128'(0));

      // Single beat
      m_axis_tready = 1'b1;
      push(64'h0123456789ABCDEF, 8'hFF, 8'h01, 8'h02, 1'b1);
      chk("t1_valid_at_push", 128'(m_axis_tvalid), 128'(0));
      chk("t1_level_at_push", 128'(level),         128'(1));
      tick();
      chk("t1_valid",  128'(m_axis_tvalid), 128'(1));
      chk("t1_data",   128'(m_axis_tdata),  128'(64'h0123456789ABCDEF));
      chk("t1_last",   128'(m_axis_tlast),  128'(1));
      tick();
      chk("t1_done_valid", 128'(m_axis_tvalid), 128'(0));
      chk("t1_beats",      128'(beat_count),    128'(1));
      chk("t1_pkts",       128'(pkt_count),     128'(1));
      chk("t1_level",      128'(level),         128'(0));

      // Backpressure
      m_axis_tready = 1'b0;
      push(64'hA1, 8'h0F, 8'h03, 8'h04, 1'b0);
      push(64'hA2, 8'hFF, 8'h03, 8'h04, 1'b0);
      push(64'hA3, 8'hFF, 8'h03, 8'h04, 1'b1);
      for (int i = 0; i < 10; i++) begin
         chk("t2_stall_valid", 128'(m_axis_tvalid), 128'(1));
         chk("t2_stall_data",  128'(m_axis_tdata),  128'(64'hA1));
         tick();
      end
      m_axis_tready = 1'b1;
      tick();
      chk("t2_beat2", 128'(m_axis_tdata), 128'(64'hA2));
      tick();
      chk("t2_beat3", 128'(m_axis_tdata), 128'(64'hA3));
      chk("t2_beat3_valid", 128'(m_axis_tvalid), 128'(1));
      tick();
      chk("t2_drained", 128'(m_axis_tvalid), 128'(0));
      chk("t2_beats",   128'(beat_count),    128'(4));
      chk("t2_pkts",    128'(pkt_count),     128'(2));

      // Gap of three idle cycles between beats
      enable = 1'b0;
      gap    = 8'd3;
      for (int i = 0; i < 4; i++) push(64'hB0 + 64'(i), 8'hFF, 8'h00, 8'h00, i == 3);
      tick();
      chk("t3_held_off", 128'(m_axis_tvalid), 128'(0));
      chk("t3_level",    128'(level),         128'(4));
      enable = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         pat[i] = m_axis_tvalid;
      end
      chk("t3_gap_pattern", 128'(pat),        128'(16'h1111));
      chk("t3_beats",       128'(beat_count), 128'(8));
      gap = 8'd0;
      repeat (5) tick();

      // Fill to full, overflow, drain
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 17; i++) push(64'hC00 + 64'(i), 8'hFF, 8'h00, 8'h00, i == 17);
      chk("t4_level17",  128'(level),    128'(17));
      chk("t4_full",     128'(wr_full),  128'(1));
      chk("t4_no_ovf",   128'(overflow), 128'(0));
      push(64'hC12, 8'hFF, 8'h00, 8'h00, 1'b0);
      chk("t4_ovf",          128'(overflow), 128'(1));
      chk("t4_level_after",  128'(level),    128'(17));
      m_axis_tready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 25; i++) begin
         if (m_axis_tvalid) cnt++;
         tick();
      end
      chk("t4_drain_count", 128'(cnt),        128'(17));
      chk("t4_level0",      128'(level),      128'(0));
      chk("t4_beats",       128'(beat_count), 128'(25));
      chk("t4_pkts",        128'(pkt_count),  128'(4));

      // Enable gating
      m_axis_tready = 1'b0;
      enable        = 1'b0;
      push(64'hD1, 8'hFF, 8'h00, 8'h00, 1'b0);
      push(64'hD2, 8'hFF, 8'h00, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("t5_gated", 128'(m_axis_tvalid), 128'(0));
         tick();
      end
      chk("t5_level2", 128'(level), 128'(2));
      enable = 1'b1;
      tick();
      chk("t5_loaded", 128'(m_axis_tvalid), 128'(1));
      chk("t5_d1",     128'(m_axis_tdata),  128'(64'hD1));
      enable = 1'b0;
      repeat (3) tick();
      chk("t5_kept_valid", 128'(m_axis_tvalid), 128'(1));
      chk("t5_kept_data",  128'(m_axis_tdata),  128'(64'hD1));
      m_axis_tready = 1'b1;
      tick();
      chk("t5_no_reload", 128'(m_axis_tvalid), 128'(0));
      chk("t5_level1",    128'(level),         128'(1));
      enable = 1'b1;
      tick();
      chk("t5_d2", 128'(m_axis_tdata), 128'(64'hD2));
      tick();
      chk("t5_beats", 128'(beat_count), 128'(27));
      chk("t5_pkts",  128'(pkt_count),  128'(5));

      // Reset mid-packet
      m_axis_tready = 1'b0;
      push(64'hE1, 8'hFF, 8'h00, 8'h00, 1'b0);
      push(64'hE2, 8'hFF, 8'h00, 8'h00, 1'b0);
      push(64'hE3, 8'hFF, 8'h00, 8'h00, 1'b1);
      chk("t6_e1", 128'(m_axis_tdata), 128'(64'hE1));
      m_axis_tready = 1'b1;
      tick();
      chk("t6_e2",    128'(m_axis_tdata), 128'(64'hE2));
      chk("t6_beats", 128'(beat_count),   128'(28));
      m_axis_tready = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t6_rst_valid", 128'(m_axis_tvalid), 128'(0));
      chk("t6_rst_level", 128'(level),         128'(0));
      chk("t6_rst_beats", 128'(beat_count),    128'(0));
      chk("t6_rst_pkts",  128'(pkt_count),     128'(0));
      chk("t6_rst_ovf",   128'(overflow),      128'(0));
      m_axis_tready = 1'b1;
      push(64'hF1, 8'hFF, 8'h00, 8'h00, 1'b1);
      tick();
      chk("t6_f1", 128'(m_axis_tdata), 128'(64'hF1));
      tick();
      chk("t6_post_beats", 128'(beat_count), 128'(1));
      chk("t6_post_pkts",  128'(pkt_count),  128'(1));

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
